// File: rtl/reset_seq_pkg.sv
// Purpose: shared types and default constants for the reset sequencer and its users.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    ASSERT,
    RELEASE,
    RUN
  } state_t;

  localparam int DEF_MIN_ASSERT = 16;
  localparam int DEF_STAGE_GAP  = 8;
  localparam int DEF_NUM_STAGES = 3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync2.sv
// Purpose: 2-flop synchronizer for a single asynchronous level into the clk domain.
// Latency: 2 clk edges from d to q.
// Backpressure: none; q follows d continuously.
// Ports: clk, reset (async active-high, q resets to 0), d (async input), q (synchronized).
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Purpose: staged core reset generator driven by PLL lock and reset requests.
// Latency: lock->ASSERT 3 edges; rst_out[0] falls MIN_ASSERT edges after ASSERT entry, then one bit per STAGE_GAP.
// Backpressure: none; reset_req or lock loss aborts any sequence and restarts it.
// Ports: clk, reset (async active-high), pll_locked (async), reset_req (sync level),
//        rst_out[NUM_STAGES] (bit 0 released first), busy (|rst_out), done (1-cycle pulse on last release).
// Optional: define RESET_SEQ_COUNT_EN to add reset_count[7:0], a saturating count of done pulses.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int MIN_ASSERT = DEF_MIN_ASSERT,
  parameter int STAGE_GAP  = DEF_STAGE_GAP
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_locked,
  input  logic                  reset_req,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  busy,
  output logic                  done
`ifdef RESET_SEQ_COUNT_EN
  ,
  output logic [7:0]            reset_count
`endif
);

  localparam int CW = $clog2(max2(MIN_ASSERT, STAGE_GAP) + 1);
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0]         ASSERT_LAST = CW'(MIN_ASSERT - 1);
  localparam logic [CW-1:0]         GAP_LAST    = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0]         LAST_IDX    = IW'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] ALL_ON      = '1;

  logic          lock_s;
  state_t        state;
  logic [CW-1:0] cnt;
  // Index of the stage the next release will clear.
  logic [IW-1:0] idx;

  sync2 u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_locked),
    .q     (lock_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= WAIT_LOCK;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= ALL_ON;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == WAIT_LOCK) begin
        rst_out <= ALL_ON;
        busy    <= 1'b1;
        cnt     <= '0;
        if (lock_s) state <= ASSERT;
      end else if (!lock_s) begin
        // Lock loss outranks everything, including a pending request.
        state   <= WAIT_LOCK;
        rst_out <= ALL_ON;
        busy    <= 1'b1;
        cnt     <= '0;
      end else if (reset_req) begin
        // In ASSERT this just pins the counter at 0; elsewhere it aborts,
        // cancelling any release that would have happened on this edge.
        state   <= ASSERT;
        rst_out <= ALL_ON;
        busy    <= 1'b1;
        cnt     <= '0;
      end else begin
        case (state)
          ASSERT: begin
            if (cnt == ASSERT_LAST) begin
              cnt <= '0;
              if (NUM_STAGES == 1) begin
                state   <= RUN;
                rst_out <= '0;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                state   <= RELEASE;
                rst_out <= rst_out << 1;
                idx     <= IW'(1);
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RELEASE: begin
            if (cnt == GAP_LAST) begin
              cnt     <= '0;
              // Released bits are low, so shifting zeros in clears exactly one more stage.
              rst_out <= rst_out << 1;
              if (idx == LAST_IDX) begin
                state <= RUN;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            // RUN: outputs hold their released values.
          end
        endcase
      end
    end
  end

`ifdef RESET_SEQ_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reset_count <= 8'd0;
    end else if (done && (reset_count != 8'hFF)) begin
      reset_count <= reset_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Purpose: self-checking bench for reset_sequencer with directed scenarios and random requests/lock drops.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_reset_sequencer;

  localparam int N      = 3;
  localparam int MINA   = 16;
  localparam int GAP    = 8;
  localparam int DONE_E = MINA + (N - 1) * GAP;

  logic         clk = 1'b0;
  logic         reset;
  logic         pll_locked;
  logic         reset_req;
  logic [N-1:0] rst_out;
  logic         busy;
  logic         done;
`ifdef RESET_SEQ_COUNT_EN
  logic [7:0]   reset_count;
`endif

  int errors = 0;
  int checks = 0;
  int edge_no = 0;

  // Reference model: lock history, "waiting for lock" flag, and elapsed
  // edges since the last (re)start of the assert window.
  bit           h1, h2;
  bit           m_wait;
  int           m_e;
  bit           m_done;
  int           m_cnt;
  logic [N-1:0] exp_rst;

  reset_sequencer #(
    .NUM_STAGES (N),
    .MIN_ASSERT (MINA),
    .STAGE_GAP  (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_locked (pll_locked),
    .reset_req  (reset_req),
    .rst_out    (rst_out),
    .busy       (busy),
    .done       (done)
`ifdef RESET_SEQ_COUNT_EN
    ,
    .reset_count (reset_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  task automatic model_reset();
    h1      = 1'b0;
    h2      = 1'b0;
    m_wait  = 1'b1;
    m_e     = 0;
    m_done  = 1'b0;
    m_cnt   = 0;
    exp_rst = '1;
  endtask

  task automatic model_edge();
    bit ls;
    int k;
    if (m_done && m_cnt < 255) m_cnt++;
    ls = h2;
    h2 = h1;
    h1 = pll_locked;
    m_done = 1'b0;
    if (m_wait) begin
      if (ls) begin
        m_wait = 1'b0;
        m_e    = 0;
      end
    end else if (!ls) begin
      m_wait = 1'b1;
    end else if (reset_req) begin
      m_e = 0;
    end else begin
      if (m_e < 1000000) m_e++;
      if (m_e == DONE_E) m_done = 1'b1;
    end
    if (m_wait) begin
      exp_rst = '1;
    end else begin
      k = (m_e < MINA) ? 0 : 1 + (m_e - MINA) / GAP;
      if (k >= N) exp_rst = '0;
      else        exp_rst = {N{1'b1}} << k;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_no++;
    model_edge();
    chk("rst_out", 32'(rst_out), 32'(exp_rst));
    chk("busy", 32'(busy), 32'(|exp_rst));
    chk("done", 32'(done), 32'(m_done));
`ifdef RESET_SEQ_COUNT_EN
    chk("reset_count", 32'(reset_count), 32'(m_cnt));
`endif
  endtask

  initial begin
    int e110, e100, e000, edone, ndone, found, drop_left;

    reset      = 1'b1;
    pll_locked = 1'b1;
    reset_req  = 1'b0;
    model_reset();
    #1;
    chk("reset_rst_out", 32'(rst_out), 32'h7);
    chk("reset_busy", 32'(busy), 32'h1);
    chk("reset_done", 32'(done), 32'h0);
    #1;
    reset = 1'b0;

    // Power-up sequence with exact release edges.
    e110 = 0; e100 = 0; e000 = 0; edone = 0; ndone = 0;
    repeat (40) begin
      tick();
      if (e110 == 0 && rst_out == 3'b110) e110 = edge_no;
      if (e100 == 0 && rst_out == 3'b100) e100 = edge_no;
      if (e000 == 0 && rst_out == 3'b000) e000 = edge_no;
      if (done) begin ndone++; edone = edge_no; end
    end
    chk("edge_110", 32'(e110), 32'd19);
    chk("edge_100", 32'(e100), 32'd27);
    chk("edge_000", 32'(e000), 32'd35);
    chk("edge_done", 32'(edone), 32'd35);
    chk("powerup_done_count", 32'(ndone), 32'd1);

    // One-cycle request in RUN restarts a full sequence.
    reset_req = 1'b1;
    tick();
    reset_req = 1'b0;
    chk("req_run_rst", 32'(rst_out), 32'h7);
    ndone = 0;
    repeat (40) begin tick(); if (done) ndone++; end
    chk("req_run_done_count", 32'(ndone), 32'd1);

    // Request held 40 cycles: first release exactly 16 edges after it drops.
    reset_req = 1'b1;
    repeat (40) tick();
    reset_req = 1'b0;
    found = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (found == 0 && rst_out == 3'b110) found = i;
    end
    chk("held_req_release", 32'(found), 32'd16);
    repeat (20) tick();

    // Abort two cycles after rst_out[0] releases: no done for that sequence.
    reset_req = 1'b1;
    tick();
    reset_req = 1'b0;
    ndone = 0;
    repeat (18) begin tick(); if (done) ndone++; end
    chk("pre_abort_rst", 32'(rst_out), 32'h6);
    reset_req = 1'b1;
    tick();
    reset_req = 1'b0;
    chk("abort_rst", 32'(rst_out), 32'h7);
    chk("abort_no_done", 32'(ndone), 32'd0);
    ndone = 0;
    repeat (34) begin tick(); if (done) ndone++; end
    chk("abort_restart_done", 32'(ndone), 32'd1);

    // Lock loss in RUN, then recovery.
    pll_locked = 1'b0;
    found = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (found == 0 && rst_out == 3'b111) found = i;
    end
    chk("lock_loss_edges", 32'(found), 32'd3);
    repeat (10) tick();
    pll_locked = 1'b1;
    ndone = 0;
    repeat (40) begin tick(); if (done) ndone++; end
    chk("relock_done_count", 32'(ndone), 32'd1);

    // Async reset between edges in the middle of RELEASE.
    reset_req = 1'b1;
    tick();
    reset_req = 1'b0;
    repeat (20) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_rst_out", 32'(rst_out), 32'h7);
    chk("arst_busy", 32'(busy), 32'h1);
    chk("arst_done", 32'(done), 32'h0);
`ifdef RESET_SEQ_COUNT_EN
    chk("arst_count", 32'(reset_count), 32'h0);
`endif
    model_reset();
    #2;
    reset = 1'b0;
    repeat (40) tick();

    // Random requests and lock drops against the model.
    drop_left = 0;
    repeat (3000) begin
      reset_req = ($urandom_range(0, 63) == 0);
      if (drop_left > 0) begin
        pll_locked = 1'b0;
        drop_left--;
      end else begin
        pll_locked = 1'b1;
        if ($urandom_range(0, 499) == 0) drop_left = $urandom_range(1, 12);
      end
      tick();
    end
    pll_locked = 1'b1;
    reset_req  = 1'b0;
    repeat (40) tick();

`ifdef RESET_SEQ_COUNT_EN
    // Saturation of the done counter.
    for (int s = 0; s < 300; s++) begin
      reset_req = 1'b1;
      tick();
      reset_req = 1'b0;
      repeat (34) tick();
    end
    chk("count_saturated", 32'(reset_count), 32'd255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
